// File: rtl/state_stack.sv
// state_stack: LIFO of recursion frames with replace, masked update, clear and registered random read.
//   clk, rst_n              clock, asynchronous active-low reset
//   clr                     synchronous clear (count and error flags)
//   push, push_data, pop    stack operations; push+pop replaces the top entry
//   top_data, top_addr      current top entry and its address (0 when empty)
//   count, empty, full      occupancy
//   upd_en/addr/mask/data   masked in-place write of a live entry
//   rd_en, rd_addr          random read request
//   rd_data, rd_valid, rd_hit  read response one cycle later
//   err_ovf, err_udf        sticky overflow / underflow flags
module state_stack #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] top_data,
   output logic [ADDR_W-1:0] top_addr,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic [DATA_W-1:0] upd_mask,
   input  logic [DATA_W-1:0] upd_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_hit,
   output logic              err_ovf,
   output logic              err_udf
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   top_idx;
   logic [ADDR_W:0]   count_nxt;
   logic [ADDR_W-1:0] wr_addr;
   logic              rep;
   logic              do_wr;
   logic              do_upd;
   logic              rd_in_range;

   assign empty       = count == '0;
   assign full        = count == (ADDR_W+1)'(DEPTH);
   assign top_idx     = count - 1'b1;
   assign top_addr    = empty ? '0 : top_idx[ADDR_W-1:0];
   assign top_data    = empty ? '0 : mem[top_addr];
   // push+pop on a non-empty stack overwrites the top slot, legal even when full
   assign rep         = push && pop && !empty;
   assign do_wr       = !clr && push && (rep || !full);
   assign wr_addr     = rep ? top_idx[ADDR_W-1:0] : count[ADDR_W-1:0];
   assign do_upd      = !clr && upd_en && ({1'b0, upd_addr} < count);
   assign rd_in_range = {1'b0, rd_addr} < count;

   always_comb
      count_nxt = clr                        ? '0 :
                  (push && !rep && !full)    ? count + 1'b1 :
                  (pop && !push && !empty)   ? count - 1'b1 :
                                               count;

   // push write is issued last so it wins over an update of the same slot
   always_ff @(posedge clk) begin
      if (do_upd) mem[upd_addr] <= (mem[upd_addr] & ~upd_mask) | (upd_data & upd_mask);
      if (do_wr) mem[wr_addr] <= push_data;
   end

   // the read samples pre-edge memory and count, so same-cycle writes and clr are not seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_hit   <= 1'b0;
         err_ovf  <= 1'b0;
         err_udf  <= 1'b0;
      end else begin
         count    <= count_nxt;
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_hit  <= rd_in_range;
            rd_data <= rd_in_range ? mem[rd_addr] : '0;
         end
         err_ovf  <= !clr && (err_ovf || (push && !pop && full));
         err_udf  <= !clr && (err_udf || (pop && !push && empty));
      end
   end
endmodule

// File: doc/state_stack.md
Name: state_stack

Overview:
- Parametrised recursion-state store for the accelerator's search engine. Each entry records one recursion frame: caller position, parent-argument address and a done flag (bit 0).
- Replaces the append-only state regfile with a true LIFO: push, pop, push+pop replace, in-place masked field update, clear, registered random read, occupancy flags and sticky error flags.
- Sits between the recursion controller, which pushes, pops and marks frames done, and the backtrace unit, which reads frames at random.

Parameters:
DATA_W, 16, entry width; bit 0 is the done flag, upper bits are opaque payload.
DEPTH, 4096, number of entries; power of two, at least 2.
ADDR_W, 12, entry address width; must equal log2(DEPTH).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of the stack
push  input  1  push push_data onto the stack
push_data  input  DATA_W  entry to push
pop  input  1  remove the top entry
top_data  output  DATA_W  current top entry, combinational; 0 when empty
top_addr  output  ADDR_W  address of the top entry (count-1); 0 when empty
count  output  ADDR_W+1  number of valid entries
empty  output  1  count==0
full  output  1  count==DEPTH
upd_en  input  1  masked in-place write enable
upd_addr  input  ADDR_W  entry address to update
upd_mask  input  DATA_W  per-bit write mask; 1 = take upd_data
upd_data  input  DATA_W  update data
rd_en  input  1  random read request
rd_addr  input  ADDR_W  random read address
rd_data  output  DATA_W  read data, 1-cycle latency; 0 on a miss
rd_valid  output  1  pulses 1 the cycle after rd_en
rd_hit  output  1  qualifies rd_data: rd_addr was below count when sampled
err_ovf  output  1  sticky: push while full, without pop
err_udf  output  1  sticky: pop while empty

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, rd_data=0, rd_valid=0, rd_hit=0, err_ovf=0, err_udf=0. Memory contents are not reset. Outputs derived from count read as empty: top_data=0, top_addr=0, empty=1, full=0.
- A reset asserted mid-operation discards any in-flight read; rd_valid stays 0 until rd_en is sampled again after release.
- Priority each cycle: clr, then push/pop, then upd.
- clr: count becomes 0 and both error flags clear. Push, pop and upd are ignored that cycle. A random read sampled in the same cycle still completes against the pre-clear state.
- Push only, not full: mem[count] <= push_data; count+1.
- Push only, full: no write, count unchanged, err_ovf set.
- Pop only, not empty: count-1. Memory is untouched.
- Pop only, empty: no change, err_udf set.
- Push and pop together, not empty: mem[count-1] <= push_data, count unchanged. This is legal even when full.
- Push and pop together, empty: behaves as push only; err_udf stays clear.
- upd_en with upd_addr < count evaluated before this cycle's push/pop: mem[a] <= (mem[a] & ~upd_mask) | (upd_data & upd_mask).
- upd_en with upd_addr >= count: silently ignored.
- upd_en on an entry being popped this cycle: the update is applied to the dead slot, with no visible effect.
- upd_en and a push+pop replace hitting the same entry: the push data wins entirely.
- Random read: sampled on the edge where rd_en=1, using the pre-edge memory and count. The next cycle gives rd_valid=1 and rd_hit=(rd_addr<count); rd_data=mem[rd_addr] on a hit, else 0.
- A write to the read address in the sampling cycle returns the old data.
- Back-to-back reads: one per cycle, fully pipelined.
- top_data and top_addr follow count combinationally from the registered state: post-edge values, no bypass of the current inputs.
- count arithmetic is ADDR_W+1 bits and never wraps; push-at-full and pop-at-empty are blocked as above.
- Error flags are cleared only by reset or clr.

Test Plan:
- Push 0x0011, 0x0022, 0x0033 -> count=3, top_data=0x0033, top_addr=2; pop once -> top_data=0x0022, count=2, empty=0.
- Push+pop together with count=2 and data 0xABCD -> count=2, top_data=0xABCD; a read of addr 0 the next cycle -> rd_data=0x0011, rd_hit=1.
- DEPTH=8: push 8 entries -> full=1; 9th push -> err_ovf=1, count=8, top unchanged; pop on an empty stack -> err_udf=1, count=0; clr -> both flags 0.
- upd_en addr=1, mask=0x0001, data=0x0001 on entry 0x0022 -> entry reads 0x0023; upd_addr=5 with count=2 -> no change to any entry.
- rd_en addr=3 with count=2 -> one cycle later rd_valid=1, rd_hit=0, rd_data=0; rd_en addr=1 in the same cycle as upd on addr 1 -> returns the pre-update value; next read returns the updated value.
- rst_n dropped mid-sequence with count=5 and a read in flight -> immediately count=0, empty=1, rd_valid=0, flags 0; after release, push 0x0044 -> top_addr=0, top_data=0x0044.
